conv_mac_accumulate: RTL and testbench

//  Downstream stage of the indexing controller. Consumes image/filter RAM read data issued by the indexer,

---
 rtl/conv_mac_accumulate.sv | 152 +++++++++++++++
 tb/tb_conv_mac_accumulate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_accumulate.sv
// Convolution MAC/accumulate stage: multiplies image x filter taps, sums one window, writes to FEATURE RAM.
// Optional build macro CONV_RELU_EN clamps negative window sums to zero before saturation.
module conv_mac_accumulate #(
  parameter int DW     = 8,
  parameter int TAPS   = 9,
  parameter int RD_LAT = 1,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 20,
  parameter int AW     = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IMAGE_RAM_EN,
  input  logic          FILTER_RAM_EN,
  input  logic [DW-1:0] IMAGE_RAM_DOUT,
  input  logic [DW-1:0] FILTER_RAM_DOUT,
  input  logic          Load_done,
  input  logic          Whole_done,
  input  logic [AW-1:0] FEATURE_RAM_ADDR,
  output logic          FEATURE_WE,
  output logic [AW-1:0] FEATURE_WADDR,
  output logic [OUT_W-1:0] FEATURE_DIN,
  output logic          Busy,
  output logic          Conv_done,
  output logic          Tap_err
);

  localparam int CW = $clog2(TAPS + 1) + 1;

  // Strobe semantics: there is no back-pressure. A tap is valid in the cycle both RAM enables are high;
  // its data shows up on the DOUT buses RD_LAT cycles later. Load_done/Whole_done/address travel with it.
  logic          tap_v;
  logic [RD_LAT-1:0] dl_tap, dl_ld, dl_wd;
  logic [AW-1:0] dl_addr [RD_LAT];

  logic                    m_tap, m_ld, m_wd;
  logic [AW-1:0]           m_addr;
  logic signed [2*DW-1:0]  m_prod;

  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           tap_cnt;
  logic                    final_wr;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] post_val;
  logic [OUT_W-1:0]        sat_val;
  logic [CW-1:0]           cnt_next;
  logic                    done;
  logic                    window_open;

  assign tap_v = IMAGE_RAM_EN & FILTER_RAM_EN;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dl_tap <= '0;
      dl_ld  <= '0;
      dl_wd  <= '0;
      for (int i = 0; i < RD_LAT; i++) dl_addr[i] <= '0;
    end else begin
      dl_tap[0]  <= tap_v;
      dl_ld[0]   <= Load_done;
      dl_wd[0]   <= Whole_done;
      dl_addr[0] <= FEATURE_RAM_ADDR;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_tap[i]  <= dl_tap[i-1];
        dl_ld[i]   <= dl_ld[i-1];
        dl_wd[i]   <= dl_wd[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

  // Multiply stage: RAM data is aligned with the last delay-line slot.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_tap  <= 1'b0;
      m_ld   <= 1'b0;
      m_wd   <= 1'b0;
      m_addr <= '0;
      m_prod <= '0;
    end else begin
      m_tap  <= dl_tap[RD_LAT-1];
      m_ld   <= dl_ld[RD_LAT-1];
      m_wd   <= dl_wd[RD_LAT-1];
      m_addr <= dl_addr[RD_LAT-1];
      if (dl_tap[RD_LAT-1])
        m_prod <= $signed({{DW{IMAGE_RAM_DOUT[DW-1]}}, IMAGE_RAM_DOUT}) *
                  $signed({{DW{FILTER_RAM_DOUT[DW-1]}}, FILTER_RAM_DOUT});
    end
  end

  always_comb begin
    window_open = (tap_cnt != '0);
    done        = m_ld | m_wd;
    prod_ext    = ACC_W'(m_prod);
    acc_next    = (window_open ? acc : '0) + (m_tap ? prod_ext : '0);
    // Counter saturates so a runaway window still reads as a mismatch.
    cnt_next    = (m_tap && (tap_cnt != '1)) ? tap_cnt + 1'b1 : tap_cnt;
  end

`ifdef CONV_RELU_EN
  always_comb post_val = acc_next[ACC_W-1] ? '0 : acc_next;
`else
  always_comb post_val = acc_next;
`endif

  generate
    if (OUT_W < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
      always_comb begin
        if (post_val > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (post_val < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
        else                         sat_val = post_val[OUT_W-1:0];
      end
    end else begin : g_pass
      always_comb sat_val = post_val[OUT_W-1:0];
    end
  endgenerate

  // Accumulate stage: a done flag closes the window, writes the result and reopens empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc           <= '0;
      tap_cnt       <= '0;
      FEATURE_WE    <= 1'b0;
      FEATURE_WADDR <= '0;
      FEATURE_DIN   <= '0;
      Tap_err       <= 1'b0;
      final_wr      <= 1'b0;
      Conv_done     <= 1'b0;
    end else begin
      FEATURE_WE <= done;
      final_wr   <= m_wd;
      Conv_done  <= final_wr;
      if (done) begin
        FEATURE_WADDR <= m_addr;
        FEATURE_DIN   <= sat_val;
        acc           <= '0;
        tap_cnt       <= '0;
        if (cnt_next != CW'(TAPS)) Tap_err <= 1'b1;
      end else begin
        acc     <= acc_next;
        tap_cnt <= cnt_next;
      end
    end
  end

  assign Busy = (|dl_tap) | (|dl_ld) | (|dl_wd) | m_tap | m_ld | m_wd | (tap_cnt != '0);

endmodule

// File: tb/tb_conv_mac_accumulate.sv
// Bench for conv_mac_accumulate: directed windows plus randomized windows checked by a queue scoreboard.
// Reference model sums image*filter per window, then applies optional ReLU and saturation arithmetically.
module tb_conv_mac_accumulate;
  localparam int DW     = 8;
  localparam int TAPS   = 9;
  localparam int RD_LAT = 1;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 12;
  localparam int AW     = 5;
  localparam int EW     = 2 + AW + OUT_W;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          IMAGE_RAM_EN = 1'b0;
  logic          FILTER_RAM_EN = 1'b0;
  logic [DW-1:0] IMAGE_RAM_DOUT;
  logic [DW-1:0] FILTER_RAM_DOUT;
  logic          Load_done = 1'b0;
  logic          Whole_done = 1'b0;
  logic [AW-1:0] FEATURE_RAM_ADDR = '0;
  logic          FEATURE_WE;
  logic [AW-1:0] FEATURE_WADDR;
  logic [OUT_W-1:0] FEATURE_DIN;
  logic          Busy;
  logic          Conv_done;
  logic          Tap_err;

  conv_mac_accumulate #(
    .DW(DW), .TAPS(TAPS), .RD_LAT(RD_LAT), .ACC_W(ACC_W), .OUT_W(OUT_W), .AW(AW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .IMAGE_RAM_EN(IMAGE_RAM_EN), .FILTER_RAM_EN(FILTER_RAM_EN),
    .IMAGE_RAM_DOUT(IMAGE_RAM_DOUT), .FILTER_RAM_DOUT(FILTER_RAM_DOUT),
    .Load_done(Load_done), .Whole_done(Whole_done), .FEATURE_RAM_ADDR(FEATURE_RAM_ADDR),
    .FEATURE_WE(FEATURE_WE), .FEATURE_WADDR(FEATURE_WADDR), .FEATURE_DIN(FEATURE_DIN),
    .Busy(Busy), .Conv_done(Conv_done), .Tap_err(Tap_err)
  );

  // Clock, cycle counter and a RAM read-latency model
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0] img_req = '0;
  logic [DW-1:0] flt_req = '0;
  logic [DW-1:0] img_pipe [RD_LAT];
  logic [DW-1:0] flt_pipe [RD_LAT];
  always @(posedge CLK) begin
    img_pipe[0] <= img_req;
    flt_pipe[0] <= flt_req;
    for (int i = 1; i < RD_LAT; i++) begin
      img_pipe[i] <= img_pipe[i-1];
      flt_pipe[i] <= flt_pipe[i-1];
    end
  end
  assign IMAGE_RAM_DOUT  = img_pipe[RD_LAT-1];
  assign FILTER_RAM_DOUT = flt_pipe[RD_LAT-1];

  // Scoreboard: {whole, sticky_err, addr, din} plus expected write cycle
  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  int            tests = 0;
  int            fails = 0;
  longint        m_sum = 0;
  int            m_cnt = 0;
  logic          m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_out(input longint s);
    longint v  = s;
    longint hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    longint lo = -hi - 1;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`endif
    if (OUT_W < ACC_W) begin
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v[OUT_W-1:0];
  endfunction

  function automatic int rnd_s();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Driver: one cycle of indexer strobes; the model is updated as the strobe is issued.
  task automatic issue(input logic ie, input logic fe, input int img, input int flt,
                       input logic ld, input logic wd, input int addr);
    @(negedge CLK);
    IMAGE_RAM_EN     = ie;
    FILTER_RAM_EN    = fe;
    img_req          = DW'(img);
    flt_req          = DW'(flt);
    Load_done        = ld;
    Whole_done       = wd;
    FEATURE_RAM_ADDR = AW'(addr);
    if (ie && fe) begin
      m_sum += longint'(img * flt);
      m_cnt++;
    end
    if (ld || wd) begin
      if (m_cnt != TAPS) m_err = 1'b1;
      exp_q.push_back({wd, m_err, AW'(addr), ref_out(m_sum)});
      cyc_q.push_back(cyc + RD_LAT + 2);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0, 0);
  endtask

  task automatic window(input int n, input int img, input int flt, input int addr, input logic whole);
    for (int i = 0; i < n; i++)
      issue(1'b1, 1'b1, img, flt, (i == n - 1) && !whole, (i == n - 1) && whole, addr);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
    repeat (3) idle();
    chk("busy_idle", Busy, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    IMAGE_RAM_EN = 1'b0;
    FILTER_RAM_EN = 1'b0;
    Load_done = 1'b0;
    Whole_done = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_err = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_we", FEATURE_WE, 0);
    chk("rst_conv_done", Conv_done, 0);
    chk("rst_tap_err", Tap_err, 0);
    chk("rst_din", FEATURE_DIN, 0);
    chk("rst_waddr", FEATURE_WADDR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Monitor: pops and compares on every FEATURE_WE, and tracks the Conv_done pulse.
  task automatic monitor();
    logic [EW-1:0] e;
    int            ec;
    logic          conv_pend = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        conv_pend = 1'b0;
      end else begin
        if (Conv_done || conv_pend) chk("conv_done", Conv_done, conv_pend);
        conv_pend = 1'b0;
        if (FEATURE_WE) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_we: write to addr %0d with none expected", FEATURE_WADDR);
          end else begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            chk("waddr", FEATURE_WADDR, e[OUT_W +: AW]);
            chk("din", longint'($signed(FEATURE_DIN)), longint'($signed(e[OUT_W-1:0])));
            chk("tap_err", Tap_err, e[EW-2]);
            chk("we_latency", cyc, ec);
            conv_pend = e[EW-1];
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    do_reset();

    // 9 taps image=1..9, filter=1, addr 5
    for (int i = 1; i <= 9; i++) begin
      issue(1'b1, 1'b1, i, 1, i == 9, 1'b0, 5);
      if (i == 3) chk("busy_mid", Busy, 1);
    end
    drain();

    // negative sum
    window(9, -4, 3, 7, 1'b0);
    drain();

    // back-to-back windows, no bubble
    window(9, 1, 2, 0, 1'b0);
    window(9, 1, 3, 1, 1'b0);
    drain();

    // short window sets sticky Tap_err; one-EN-only cycles add nothing; zero-tap close
    window(8, 2, 2, 9, 1'b0);
    issue(1'b1, 1'b0, 5, 5, 1'b0, 1'b0, 10);
    issue(1'b0, 1'b1, 5, 5, 1'b0, 1'b0, 10);
    window(9, 1, 1, 10, 1'b0);
    issue(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 11);
    drain();

    // saturation
    window(9, 127, 127, 12, 1'b0);
    window(9, -128, 127, 13, 1'b0);
    drain();

    // reset in the middle of a window
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 7, 7, 1'b0, 1'b0, 3);
    do_reset();
    repeat (4) idle();
    window(9, 3, -5, 3, 1'b0);
    drain();

    // randomized windows, last one closes the run
    for (int w = 0; w < 24; w++) begin
      int   nt;
      int   addr;
      logic last_w;
      nt     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 10)) : TAPS;
      addr   = int'($urandom_range(0, 31));
      last_w = (w == 23);
      for (int t = 0; t < nt; t++) begin
        case ($urandom_range(0, 5))
          0: issue(1'b1, 1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0, addr);
          1: issue(1'b0, 1'b1, rnd_s(), rnd_s(), 1'b0, 1'b0, addr);
          2: issue(1'b0, 1'b0, rnd_s(), rnd_s(), 1'b0, 1'b0, addr);
          default: ;
        endcase
        issue(1'b1, 1'b1, rnd_s(), rnd_s(), (t == nt - 1) && !last_w, (t == nt - 1) && last_w, addr);
      end
    end
    drain();
    chk("tap_err_final", Tap_err, m_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
